// File: rtl/dpa_fb_scanout.sv
// ---------------------------------------------------------------------------
// dpa_fb_scanout
//   Display-side reader of the DPA framebuffer. Shares the image-memory read
//   port through a req/gnt handshake, prefetches pixels into a small FIFO and
//   emits them in raster order together with de/hsync/vsync timing.
//
// Ports
//   clk       : clock, all logic on the rising edge
//   reset     : asynchronous, active-low reset
//   en        : scan-out enable; low parks the raster and the fetch engine
//   fb_base   : framebuffer base word address, sampled at frame start only
//   mem_req   : read request to the image-memory arbiter
//   mem_gnt   : grant; a read is accepted on a cycle with mem_req && mem_gnt
//   mem_a     : read address (0 while mem_req is low)
//   mem_q     : read data, valid exactly one cycle after acceptance
//   de        : pixel valid (active area), registered
//   hsync     : line sync, active high, registered
//   vsync     : frame sync, active high, registered
//   pix       : pixel {R,G,B}, 0 whenever de is 0
//   underrun  : sticky, a pixel was due while the FIFO was empty
// ---------------------------------------------------------------------------
module dpa_fb_scanout #(
  parameter int FB_W       = 256,
  parameter int FB_H       = 256,
  parameter int HBLANK     = 16,
  parameter int VBLANK     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [19:0] fb_base,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [19:0] mem_a,
  input  logic [23:0] mem_q,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] pix,
  output logic        underrun
);

  localparam int H_TOT   = FB_W + HBLANK;
  localparam int V_TOT   = FB_H + VBLANK;
  localparam int PIX_TOT = FB_W * FB_H;
  localparam int HW      = $clog2(H_TOT);
  localparam int VW      = $clog2(V_TOT);
  localparam int CW      = $clog2(PIX_TOT + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int OW      = AW + 1;

  // -------------------------------------------------------------------------
  // Raster counters. Parked at (0, FB_H) so that the first enabled cycle is
  // always a frame start and the whole vertical blank is available to
  // prefetch before the first active line.
  // -------------------------------------------------------------------------
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          de_n;
  logic          hsync_n;
  logic          vsync_n;
  logic          frame_start;

  assign h_last      = (int'(h_cnt) == H_TOT - 1);
  assign v_last      = (int'(v_cnt) == V_TOT - 1);
  assign de_n        = (int'(h_cnt) < FB_W) && (int'(v_cnt) < FB_H);
  assign hsync_n     = (int'(h_cnt) >= FB_W) && (int'(h_cnt) < FB_W + 4);
  assign vsync_n     = (int'(v_cnt) == FB_H);
  assign frame_start = en && (h_cnt == '0) && (int'(v_cnt) == FB_H);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= VW'(FB_H);
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= VW'(FB_H);
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Fetch engine. fetch_cnt == PIX_TOT means idle (frame fully fetched or
  // not yet started). pend marks a read accepted last cycle whose data is on
  // mem_q now; there is never more than one since data returns next cycle.
  // Counting pend against FIFO room guarantees the push always fits.
  // -------------------------------------------------------------------------
  logic [19:0]   fetch_addr;
  logic [CW-1:0] fetch_cnt;
  logic          pend;
  logic [OW-1:0] occ;
  logic          fetch_more;
  logic          room;
  logic          accept;

  assign fetch_more = (int'(fetch_cnt) < PIX_TOT);
  assign room       = (int'(occ) + (pend ? 1 : 0)) < FIFO_DEPTH;
  assign mem_req    = en && fetch_more && room;
  assign accept     = mem_req && mem_gnt;
  // fetch_addr only moves on acceptance, so the address holds while waiting
  assign mem_a      = mem_req ? fetch_addr : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_addr <= '0;
      fetch_cnt  <= CW'(PIX_TOT);
      pend       <= 1'b0;
    end else if (!en) begin
      fetch_cnt  <= CW'(PIX_TOT);
      pend       <= 1'b0;
    end else if (frame_start) begin
      // Base is sampled here only; a read accepted in this cycle belongs to
      // the previous frame and is dropped by clearing pend.
      fetch_addr <= fb_base;
      fetch_cnt  <= '0;
      pend       <= 1'b0;
    end else begin
      pend <= accept;
      if (accept) begin
        fetch_addr <= fetch_addr + 20'd1;
        fetch_cnt  <= fetch_cnt + CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Prefetch FIFO. Pop decisions use the occupancy at the start of the cycle,
  // so a same-cycle push into an empty FIFO is not bypassed to the output.
  // -------------------------------------------------------------------------
  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          starve;

  assign push   = pend;
  assign pop    = en && de_n && (occ != '0);
  assign starve = en && de_n && (occ == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (!en || frame_start) begin
      // Flushing realigns the pixel stream after any underrun
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registered video outputs: one cycle behind the raster counters.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de       <= 1'b0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
      pix      <= '0;
      underrun <= 1'b0;
    end else begin
      de    <= en && de_n;
      hsync <= en && hsync_n;
      vsync <= en && vsync_n;
      pix   <= pop ? fifo_mem[rd_ptr] : 24'h0;
      if (!en) begin
        underrun <= 1'b0;
      end else if (starve) begin
        underrun <= 1'b1;
      end
    end
  end

  // Occupancy plus outstanding read never exceeds the FIFO, so a push can
  // never land in a full FIFO without a matching pop.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (int'(occ) == FIFO_DEPTH)));

  a_credit_bound : assert property (@(posedge clk) disable iff (!reset)
    (int'(occ) + (pend ? 1 : 0)) <= FIFO_DEPTH);

endmodule

// File: tb/tb_dpa_fb_scanout.sv
module tb_dpa_fb_scanout;

  localparam int FB_W       = 4;
  localparam int FB_H       = 2;
  localparam int HBLANK     = 4;
  localparam int VBLANK     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int LINE       = FB_W + HBLANK;
  localparam int FRAME      = LINE * (FB_H + VBLANK);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [19:0] fb_base = '0;
  logic        mem_gnt = 1'b0;
  logic [23:0] mem_q = '0;
  logic        mem_req;
  logic [19:0] mem_a;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [23:0] pix;
  logic        underrun;

  dpa_fb_scanout #(
    .FB_W(FB_W), .FB_H(FB_H), .HBLANK(HBLANK), .VBLANK(VBLANK), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .fb_base(fb_base),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_a(mem_a), .mem_q(mem_q),
    .de(de), .hsync(hsync), .vsync(vsync), .pix(pix), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [19:0] exp_addr [$];
  logic [23:0] exp_pix  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: DUT output with no expected entry queued (t=%0t)", name, $time);
  endtask

  // Expected addresses and pixels for one frame; pixels from index 'good'
  // onward are starved slots and must read as 0.
  task automatic push_frame(input logic [19:0] base, input int good);
    for (int i = 0; i < FB_W * FB_H; i++) begin
      logic [19:0] a;
      a = base + 20'(i);
      exp_addr.push_back(a);
      exp_pix.push_back(i < good ? {4'h0, a} : 24'h0);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory: returns the accepted address as data one cycle later, noise otherwise
  logic        prev_acc  = 1'b0;
  logic [19:0] prev_addr = '0;
  always @(negedge clk) begin
    mem_q     = prev_acc ? {4'h0, prev_addr} : 24'($urandom);
    prev_acc  = reset && mem_req && mem_gnt;
    prev_addr = mem_a;
  end

  // Consecutive clock edges with en sampled high; gives the raster position
  int n_on;
  always @(posedge clk or negedge reset) begin
    if (!reset) n_on <= 0;
    else        n_on <= en ? n_on + 1 : 0;
  end

  int   m_p, m_h, m_v;
  logic m_de, m_hs, m_vs;
  always @(negedge clk) begin
    m_de = 1'b0; m_hs = 1'b0; m_vs = 1'b0;
    if (n_on > 0) begin
      m_p  = (n_on - 1) % FRAME;
      m_h  = m_p % LINE;
      m_v  = (FB_H + m_p / LINE) % (FB_H + VBLANK);
      m_de = (m_h < FB_W) && (m_v < FB_H);
      m_hs = (m_h >= FB_W) && (m_h < FB_W + 4);
      m_vs = (m_v == FB_H);
    end
    check("de", 32'(de), 32'(m_de));
    check("hsync", 32'(hsync), 32'(m_hs));
    check("vsync", 32'(vsync), 32'(m_vs));
    if (de) begin
      if (exp_pix.size() == 0) fail_now("pix_extra");
      else check("pix", 32'(pix), 32'(exp_pix.pop_front()));
    end else begin
      check("pix_idle", 32'(pix), 32'h0);
    end
    if (!en || !reset) check("req_off", 32'(mem_req), 32'h0);
    if (mem_req && mem_gnt) begin
      if (exp_addr.size() == 0) fail_now("mem_a_extra");
      else check("mem_a", 32'(mem_a), 32'(exp_addr.pop_front()));
    end else if (mem_req && exp_addr.size() > 0) begin
      check("mem_a_hold", 32'(mem_a), 32'(exp_addr[0]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with random inputs, then idle with en=0
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      en      = 1'($urandom);
      fb_base = 20'($urandom);
      mem_gnt = 1'($urandom);
      @(negedge clk);
      check("rst_req", 32'(mem_req), 32'h0);
      check("rst_mem_a", 32'(mem_a), 32'h0);
      check("rst_underrun", 32'(underrun), 32'h0);
    end
    tick(1);
    en = 1'b0; mem_gnt = 1'b1; fb_base = 20'h0;
    reset = 1'b1;
    tick(6);

    // 2: two clean frames from 0x100
    fb_base = 20'h00100;
    push_frame(20'h00100, 8);
    push_frame(20'h00100, 8);
    en = 1'b1;
    tick(63);
    @(negedge clk); check("t2_underrun", 32'(underrun), 32'h0);
    tick(1);
    en = 1'b0;
    tick(4);

    // 3: grant withheld 10 cycles mid-line -> starved second line, recovery next frame
    push_frame(20'h00100, 4);
    push_frame(20'h00100, 8);
    en = 1'b1;
    tick(17);
    mem_gnt = 1'b0;
    tick(10);
    mem_gnt = 1'b1;
    tick(36);
    @(negedge clk); check("t3_underrun_set", 32'(underrun), 32'h1);
    tick(1);
    en = 1'b0;
    tick(2);
    @(negedge clk); check("t3_underrun_clear", 32'(underrun), 32'h0);
    tick(2);

    // 4: base change mid active frame takes effect next frame
    push_frame(20'h00100, 8);
    push_frame(20'h00200, 8);
    en = 1'b1;
    tick(18);
    fb_base = 20'h00200;
    tick(45);
    @(negedge clk); check("t4_underrun", 32'(underrun), 32'h0);
    tick(1);
    en = 1'b0;
    tick(4);

    // 5: en drops the cycle after an accepted read; restart from a new base
    fb_base = 20'h00300;
    exp_addr.push_back(20'h00300);
    en = 1'b1;
    tick(2);
    en = 1'b0;
    tick(5);
    fb_base = 20'h00380;
    push_frame(20'h00380, 8);
    en = 1'b1;
    tick(31);
    @(negedge clk); check("t5_underrun", 32'(underrun), 32'h0);
    tick(1);
    en = 1'b0;
    tick(4);

    // Reset in the middle of fetching; the pending return must be ignored
    fb_base = 20'h00100;
    exp_addr.push_back(20'h00100);
    exp_addr.push_back(20'h00101);
    en = 1'b1;
    tick(3);
    reset = 1'b0;
    en = 1'b0;
    @(negedge clk);
    check("mid_rst_req", 32'(mem_req), 32'h0);
    check("mid_rst_underrun", 32'(underrun), 32'h0);
    tick(2);
    reset = 1'b1;
    tick(3);

    // 6: address wrap at the top of the 20-bit space
    fb_base = 20'hFFFFE;
    push_frame(20'hFFFFE, 8);
    en = 1'b1;
    tick(32);
    en = 1'b0;
    tick(4);

    check("pix_queue_drained", 32'(exp_pix.size()), 32'h0);
    check("addr_queue_drained", 32'(exp_addr.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
